// File: rtl/reg_async_req_ctrl.sv
// ---------------------------------------------------------------------------
// reg_async_req_ctrl
//   Bus-side controller for an asynchronous register field. It sequences a
//   single outstanding bus request at a time against an async subreg. Writes
//   issue a one-cycle write strobe and then wait for the crossing to finish.
//   Reads return the current subreg readback value. A bounded wait turns a
//   stuck crossing into an error response. A free-running counter produces
//   the periodic sample pulse that the subreg uses to refresh its readback.
//
// Parameters
//   DW          data width of the register field
//   UPD_PERIOD  cycles between src_update_o pulses (2..256)
//   TIMEOUT     WAIT cycles allowed before an error response (2..1024)
//
// Ports
//   i_clk, i_rst  clock, synchronous active-high reset
//   req_*         request channel (valid/ready, write flag, write data)
//   rsp_*         response channel (valid/ready, read data, error flag)
//   src_update_o  periodic sample pulse to the async subreg
//   src_we_o      single-cycle write strobe to the async subreg
//   src_wd_o      write data to the async subreg
//   src_busy_i    async subreg crossing in progress
//   src_qs_i      async subreg readback value
// ---------------------------------------------------------------------------
module reg_async_req_ctrl #(
  parameter int unsigned DW         = 32,
  parameter int unsigned UPD_PERIOD = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_write_i,
  input  logic [DW-1:0] req_wdata_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          rsp_err_o,
  output logic          src_update_o,
  output logic          src_we_o,
  output logic [DW-1:0] src_wd_o,
  input  logic          src_busy_i,
  input  logic [DW-1:0] src_qs_i
);

  localparam int unsigned UCW = (UPD_PERIOD > 1) ? $clog2(UPD_PERIOD) : 1;
  localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [UCW-1:0] UPD_LAST  = UCW'(UPD_PERIOD - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [UCW-1:0] upd_cnt_q;

  logic           accept;
  logic           wd_load;
  logic           rsp_load;
  logic [DW-1:0]  rsp_rdata_d;
  logic           rsp_err_d;

  // Ready is decoded from state so a busy crossing blocks acceptance in the
  // same cycle; it is also held low while reset is applied.
  assign req_ready_o = (state_q == S_IDLE) && !src_busy_i && !i_rst;
  assign accept      = req_valid_i && req_ready_o;

  // Next-state and datapath load decisions.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    wd_load     = 1'b0;
    rsp_load    = 1'b0;
    rsp_rdata_d = src_qs_i;
    rsp_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_write_i) begin
            wd_load = 1'b1;
            state_d = S_ISSUE;
          end else begin
            rsp_load = 1'b1;
            state_d  = S_RESP;
          end
        end
      end

      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (!src_busy_i) begin
          rsp_load = 1'b1;
          state_d  = S_RESP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Crossing never finished: report an error with zeroed data.
          rsp_load    = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Registered strobes decoded from the next state, so they line up exactly
  // with the ISSUE and RESP cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      src_we_o    <= 1'b0;
      rsp_valid_o <= 1'b0;
    end else begin
      src_we_o    <= (state_d == S_ISSUE);
      rsp_valid_o <= (state_d == S_RESP);
    end
  end

  // Write data and response payload only change on their load events, which
  // keeps them stable through ISSUE/WAIT and the whole RESP stall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      src_wd_o    <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      if (wd_load) begin
        src_wd_o <= req_wdata_i;
      end
      if (rsp_load) begin
        rsp_rdata_o <= rsp_rdata_d;
        rsp_err_o   <= rsp_err_d;
      end
    end
  end

  // Free-running update counter; the terminal count is registered into a
  // one-cycle pulse, so the first pulse follows UPD_PERIOD non-reset edges.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      upd_cnt_q    <= '0;
      src_update_o <= 1'b0;
    end else begin
      upd_cnt_q    <= (upd_cnt_q == UPD_LAST) ? '0 : upd_cnt_q + UCW'(1);
      src_update_o <= (upd_cnt_q == UPD_LAST);
    end
  end

endmodule

// File: tb/tb_reg_async_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_async_req_ctrl
//   Directed bench with a scoreboard: stimulus pushes the expected write
//   strobe data and expected responses into queues; a monitor pops and
//   compares whenever the DUT strobes src_we_o or completes a response.
// ---------------------------------------------------------------------------
module tb_reg_async_req_ctrl;

  localparam int unsigned DW  = 32;
  localparam int unsigned UPD = 8;
  localparam int unsigned TO  = 64;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_write_i;
  logic [DW-1:0] req_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          src_update_o;
  logic          src_we_o;
  logic [DW-1:0] src_wd_o;
  logic          src_busy_i;
  logic [DW-1:0] src_qs_i;

  int n_tests = 0;
  int n_fail  = 0;

  rsp_t          rsp_q[$];
  logic [DW-1:0] wd_q[$];

  always #5 clk = ~clk;

  reg_async_req_ctrl #(
    .DW         (DW),
    .UPD_PERIOD (UPD),
    .TIMEOUT    (TO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .src_update_o (src_update_o),
    .src_we_o     (src_we_o),
    .src_wd_o     (src_wd_o),
    .src_busy_i   (src_busy_i),
    .src_qs_i     (src_qs_i)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rsp_valid"},  64'(rsp_valid_o),  64'd0);
    check({tag, "_src_we"},     64'(src_we_o),     64'd0);
    check({tag, "_src_update"}, 64'(src_update_o), 64'd0);
    check({tag, "_rsp_err"},    64'(rsp_err_o),    64'd0);
    check({tag, "_req_ready"},  64'(req_ready_o),  64'd0);
    check({tag, "_src_wd"},     64'(src_wd_o),     64'd0);
    check({tag, "_rsp_rdata"},  64'(rsp_rdata_o),  64'd0);
  endtask

  // Present a request starting at posedge+1; the bench arranges busy low so
  // it must be accepted at the next edge. Returns at accept edge + 1.
  task automatic accept_req(input logic wr, input logic [DW-1:0] wd);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_wdata_i = wd;
    @(negedge clk);
    check("accept_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_wdata_i = ~wd;
  endtask

  // Count negedges after the accept edge until rsp_valid_o rises (bounded).
  task automatic wait_rsp_valid(input int budget, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid_o) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_wait_timeout: rsp_valid_o still 0 after %0d cycles, expected 1", budget);
      cyc = -1;
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rsp_valid_o && rsp_ready_i) begin
      if (rsp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rdata 0x%0h err %0b, expected no response", rsp_rdata_o, rsp_err_o);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
        check("rsp_err",   64'(rsp_err_o),   64'(e.err));
      end
    end
    if (src_we_o) begin
      if (wd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL we_unexpected: got src_we_o=1 wd 0x%0h, expected no strobe", src_wd_o);
      end else begin
        logic [DW-1:0] w;
        w = wd_q.pop_front();
        check("src_wd", 64'(src_wd_o), 64'(w));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    i_rst       = 1'b1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_wdata_i = '0;
    rsp_ready_i = 1'b0;
    src_busy_i  = 1'b0;
    src_qs_i    = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");

    // Release after this edge; count update pulses from the first free edge.
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    for (int k = 1; k <= 3 * int'(UPD); k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("upd_cycle%0d", k), 64'(src_update_o), 64'((k % int'(UPD)) == 0));
      if (k == 1) check("idle_ready", 64'(req_ready_o), 64'd1);
    end

    // Read, busy low: response next cycle with sampled readback.
    @(posedge clk);
    #1;
    src_qs_i    = 32'h1234_5678;
    rsp_ready_i = 1'b1;
    rsp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    accept_req(1'b0, 32'h0);
    src_qs_i = 32'hDEAD_0000;
    @(negedge clk);
    check("rd_latency_valid", 64'(rsp_valid_o), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rd_done_valid", 64'(rsp_valid_o), 64'd0);
    check("rd_done_ready", 64'(req_ready_o), 64'd1);

    // Write with busy high for three WAIT cycles.
    @(posedge clk);
    #1;
    wd_q.push_back(32'hA5A5_0001);
    accept_req(1'b1, 32'hA5A5_0001);
    @(negedge clk);
    check("wr_issue_we", 64'(src_we_o), 64'd1);
    @(posedge clk);
    #1;
    src_busy_i = 1'b1;
    @(negedge clk);
    check("wr_wait_we", 64'(src_we_o), 64'd0);
    check("wr_wait_valid", 64'(rsp_valid_o), 64'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("wr_busy_valid", 64'(rsp_valid_o), 64'd0);
      check("wr_busy_ready", 64'(req_ready_o), 64'd0);
    end
    @(posedge clk);
    #1;
    src_busy_i = 1'b0;
    src_qs_i   = 32'hCAFE_0001;
    rsp_q.push_back('{rdata: 32'hCAFE_0001, err: 1'b0});
    @(negedge clk);
    check("wr_not_early", 64'(rsp_valid_o), 64'd0);
    @(posedge clk);
    #1;
    src_qs_i = 32'hBEEF_0000;
    @(negedge clk);
    check("wr_valid_after_busy", 64'(rsp_valid_o), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wr_done_valid", 64'(rsp_valid_o), 64'd0);

    // Timeout: busy stuck high, then a 10-cycle response stall.
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
    wd_q.push_back(32'h0BAD_0BAD);
    accept_req(1'b1, 32'h0BAD_0BAD);
    src_busy_i = 1'b1;
    wait_rsp_valid(200, cyc);
    check("to_latency", 64'(cyc), 64'd66);
    src_busy_i = 1'b0;
    check("to_err", 64'(rsp_err_o), 64'd1);
    check("to_rdata", 64'(rsp_rdata_o), 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      src_qs_i = $urandom;
      @(negedge clk);
      check($sformatf("stall%0d_valid", i), 64'(rsp_valid_o), 64'd1);
      check($sformatf("stall%0d_err", i),   64'(rsp_err_o),   64'd1);
      check($sformatf("stall%0d_rdata", i), 64'(rsp_rdata_o), 64'd0);
      check($sformatf("stall%0d_ready", i), 64'(req_ready_o), 64'd0);
    end
    @(posedge clk);
    #1;
    rsp_q.push_back('{rdata: 32'h0, err: 1'b1});
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("to_idle_valid", 64'(rsp_valid_o), 64'd0);
    check("to_idle_ready", 64'(req_ready_o), 64'd1);

    // Request held while busy is ignored, then accepted once busy drops.
    @(posedge clk);
    #1;
    src_busy_i  = 1'b1;
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_wdata_i = 32'h7777_8888;
    wd_q.push_back(32'h7777_8888);
    rsp_q.push_back('{rdata: 32'h0000_AAAA, err: 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_ready", 64'(req_ready_o), 64'd0);
      check("hold_we", 64'(src_we_o), 64'd0);
      @(posedge clk);
      #1;
    end
    src_busy_i = 1'b0;
    @(negedge clk);
    check("hold_release_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    src_qs_i    = 32'h0000_AAAA;
    wait_rsp_valid(20, cyc);
    check("hold_wr_latency", 64'(cyc), 64'd3);

    // Reset in WAIT aborts the write; a fresh write then completes.
    @(posedge clk);
    #1;
    wd_q.push_back(32'h1111_2222);
    accept_req(1'b1, 32'h1111_2222);
    src_busy_i = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("abort");
    src_busy_i = 1'b0;
    @(posedge clk);
    #1;
    i_rst    = 1'b0;
    src_qs_i = 32'h00C0_FFEE;
    wd_q.push_back(32'h5A5A_0003);
    rsp_q.push_back('{rdata: 32'h00C0_FFEE, err: 1'b0});
    @(posedge clk);
    #1;
    accept_req(1'b1, 32'h5A5A_0003);
    wait_rsp_valid(20, cyc);
    check("post_rst_latency", 64'(cyc), 64'd3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
    check("wd_queue_empty", 64'(wd_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_async_req_ctrl.md
REG_ASYNC_REQ_CTRL -- requirements
Module: reg_async_req_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, data width of the register field.
REQ-002 SHALL have parameter UPD_PERIOD, default 8, cycles between src_update_o pulses; legal range 2..256.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles before an error response; legal range 2..1024.
REQ-004 i_clk  input  1  single clock; all logic is rising-edge.
REQ-005 i_rst  input  1  reset; synchronous and active-high.
REQ-006 req_valid_i  input  1  bus request valid.
REQ-007 req_ready_o  output  1  request accepted when high together with req_valid_i.
REQ-008 req_write_i  input  1  1 = write, 0 = read.
REQ-009 req_wdata_i  input  DW  write data.
REQ-010 rsp_valid_o  output  1  response valid.
REQ-011 rsp_ready_i  input  1  response consumed when high together with rsp_valid_o.
REQ-012 rsp_rdata_o  output  DW  readback data.
REQ-013 rsp_err_o  output  1  response error (timeout).
REQ-014 src_update_o  output  1  periodic sample pulse to the async subreg.
REQ-015 src_we_o  output  1  single-cycle write strobe to the async subreg.
REQ-016 src_wd_o  output  DW  write data to the async subreg.
REQ-017 src_busy_i  input  1  async subreg crossing in progress.
REQ-018 src_qs_i  input  DW  async subreg readback value.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-020 req_ready_o SHALL be high only in IDLE with src_busy_i low.
REQ-021 Accepted write SHALL latch req_wdata_i into src_wd_o and transition IDLE->ISSUE.
REQ-022 Accepted read SHALL latch src_qs_i into rsp_rdata_o, clear rsp_err_o, and transition IDLE->RESP.
REQ-023 In ISSUE, src_we_o SHALL be high for exactly that one cycle, then transition to WAIT.
REQ-024 WAIT SHALL last at least one cycle; src_busy_i low in WAIT SHALL latch src_qs_i into rsp_rdata_o, clear rsp_err_o, and transition to RESP.
REQ-025 WAIT cycle counter SHALL clear on entry and increment each WAIT cycle with src_busy_i high.
REQ-026 Counter reaching TIMEOUT-1 with src_busy_i still high SHALL set rsp_err_o=1, rsp_rdata_o=0, and transition to RESP.
REQ-027 rsp_valid_o SHALL be high exactly in RESP.
REQ-028 rsp_rdata_o and rsp_err_o SHALL be held stable while rsp_valid_o is high.
REQ-029 RESP SHALL return to IDLE on rsp_ready_i; otherwise it holds.
REQ-030 Write latency, with src_busy_i low in the first WAIT cycle, SHALL be: accept cycle N, src_we_o at N+1, WAIT N+2, rsp_valid_o at N+3.
REQ-031 Read latency SHALL be: accept at N, rsp_valid_o at N+1.
REQ-032 src_wd_o SHALL hold its value outside ISSUE (no other update).
REQ-033 Update counter SHALL be free-running, counting 0..UPD_PERIOD-1 and wrapping to 0.
REQ-034 src_update_o SHALL be high for the single cycle where the update counter equals UPD_PERIOD-1, independent of FSM state.
REQ-035 req_valid_i while req_ready_o is low SHALL be ignored (no state change); the requester holds its request.
REQ-036 Only one request SHALL be outstanding; no new acceptance is allowed in the same cycle as the rsp_ready_i handshake.

Reset
REQ-037 i_rst high SHALL force, at the next edge: state IDLE, all counters 0, and src_we_o, src_update_o, rsp_valid_o, rsp_err_o, req_ready_o all 0.
REQ-038 i_rst high SHALL also clear src_wd_o and rsp_rdata_o to 0.
REQ-039 Reset asserted mid-transaction (ISSUE/WAIT/RESP) SHALL abort it with no response and no further src_we_o.
REQ-040 The first src_update_o after reset release SHALL occur UPD_PERIOD cycles after the first non-reset edge.

Verification
REQ-041 Write 0xA5A5_0001, busy high 3 cycles from ISSUE+1 -> src_we_o one pulse with src_wd_o=0xA5A5_0001; rsp_valid_o 1 cycle after busy falls; rsp_err_o=0; rsp_rdata_o=src_qs_i at that cycle.
REQ-042 Read with src_qs_i=0x1234_5678, busy low -> rsp_valid_o next cycle, rsp_rdata_o=0x1234_5678, rsp_err_o=0.
REQ-043 Write with src_busy_i stuck high, TIMEOUT=64 -> rsp_err_o=1 and rsp_rdata_o=0 after 64 WAIT cycles; FSM returns to IDLE after rsp_ready_i.
REQ-044 rsp_ready_i held low 10 cycles -> rsp_valid_o and data stable all 10 cycles; req_ready_o low throughout.
REQ-045 i_rst asserted in WAIT -> all outputs 0 next cycle; after release, a new write completes normally.
REQ-046 Idle run of 3*UPD_PERIOD cycles after reset -> src_update_o pulses exactly at cycles 8, 16 and 24 (UPD_PERIOD=8), each one cycle wide.
